vec3_requant: RTL and testbench

VEC3_REQUANT -- requirements
Module: vec3_requant

---
 rtl/vec3_requant_pkg.sv | 51 +++++
 rtl/vec3_requant_stream.sv | 75 +++++++
 rtl/vec3_requant.sv | 89 ++++++++
 tb/tb_vec3_requant.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec3_requant_pkg.sv
// Shared widths, saturation limits, element types and the requantization
// helper for the vec3_requant block.
package vec3_requant_pkg;

  localparam int K_DEFAULT = 3;
  localparam int IN_W      = 28;
  localparam int OUT_W     = 14;
  localparam int SAT_MAX   = 8191;
  localparam int SAT_MIN   = -8192;

  typedef logic signed [IN_W-1:0]  in_elem_t;
  typedef logic signed [OUT_W-1:0] out_elem_t;

  // One buffer entry: requantized value plus end-of-vector marker.
  typedef struct packed {
    logic      last;
    out_elem_t data;
  } buf_entry_t;

  localparam int ENTRY_W = $bits(buf_entry_t);

  // Result of requantizing one element; sat is set only when the clamp bites.
  typedef struct packed {
    logic      sat;
    out_elem_t data;
  } requant_t;

  // Floor shift, optional ReLU, then clamp into the signed output range.
  // ReLU runs before the clamp so zeroing never counts as saturation.
  function automatic requant_t requant(in_elem_t din, int unsigned shift, logic relu);
    in_elem_t t;
    requant_t r;
    t = din >>> shift;
    if (relu && t[IN_W-1]) begin
      t = '0;
    end
    r.sat  = 1'b0;
    r.data = '0;
    if (t > in_elem_t'(SAT_MAX)) begin
      r.data = out_elem_t'(SAT_MAX);
      r.sat  = 1'b1;
    end else if (t < in_elem_t'(SAT_MIN)) begin
      r.data = out_elem_t'(SAT_MIN);
      r.sat  = 1'b1;
    end else begin
      r.data = out_elem_t'(t);
    end
    return r;
  endfunction

endpackage

// File: rtl/vec3_requant_stream.sv
// Buffer sub-module used by vec3_requant.
// Generic valid/ready FIFO with occupancy counter and power-of-two depth.
// Storage is cleared on reset and the read port reads zero while empty.
module stream_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Ready and valid derive from occupancy only, never from the other side.
  always_comb begin
    in_ready  = (r_count < CNT_W'(DEPTH));
    out_valid = (r_count != '0);
    w_push    = in_valid & in_ready;
    w_pop     = out_valid & out_ready;
    out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  end

  // Storage write on push; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
      r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer advances on each pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    r_count <= CNT_W'(DEPTH));

endmodule

// File: rtl/vec3_requant.sv
// Requantizes signed matvec result elements (shift, ReLU, clamp) into a
// narrower signed stream, tags the last element of each K-vector, buffers
// results in a small FIFO and counts saturated elements.
module vec3_requant
  import vec3_requant_pkg::*;
#(
  parameter int unsigned K       = K_DEFAULT,
  parameter int unsigned SHIFT   = 7,
  parameter int unsigned RELU_EN = 1,
  parameter int unsigned DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic [IN_W-1:0]  input_data,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [OUT_W-1:0] output_data,
  output logic             output_last,
  input  logic             sat_clear,
  output logic [15:0]      sat_count
);

  localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_sat_count;
  requant_t         w_req;
  buf_entry_t       w_in_entry;
  buf_entry_t       w_out_entry;
  logic             w_last;
  logic             w_push;
  logic             w_in_ready;
  logic             w_out_valid;

  // Transform the presented element; it only matters on an accepting edge.
  always_comb begin
    w_req           = requant(in_elem_t'(input_data), SHIFT, (RELU_EN != 0));
    w_last          = (r_idx == IDX_W'(K - 1));
    w_push          = input_valid & w_in_ready;
    w_in_entry.data = w_req.data;
    w_in_entry.last = w_last;
  end

  // Element index within the current vector, wrapping after K-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (w_push) begin
      r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Saturation counter: clear wins over increment, holds at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sat_count <= '0;
    end else if (sat_clear) begin
      r_sat_count <= '0;
    end else if (w_push && w_req.sat && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  stream_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (input_valid),
    .in_ready (w_in_ready),
    .in_data  (w_in_entry),
    .out_valid(w_out_valid),
    .out_ready(output_ready),
    .out_data (w_out_entry)
  );

  // The FIFO already reads zero when empty, so outputs need no extra gating.
  always_comb begin
    input_ready  = w_in_ready;
    output_valid = w_out_valid;
    output_data  = w_out_entry.data;
    output_last  = w_out_entry.last;
    sat_count    = r_sat_count;
  end

endmodule

// File: tb/tb_vec3_requant.sv
// Scoreboard bench: two builds (ReLU on / off) share one input stream; an
// input monitor pushes model results, an output monitor pops and compares.
module tb_vec3_requant;

  localparam int K     = 3;
  localparam int SHIFT = 7;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        input_valid = 1'b0;
  logic [27:0] input_data = '0;
  logic        output_ready = 1'b0;
  logic        sat_clear = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_last;
  logic [13:0] a_out_data;
  logic [15:0] a_sat;
  logic        b_in_ready, b_out_valid, b_out_last;
  logic [13:0] b_out_data;
  logic [15:0] b_sat;

  vec3_requant #(.K(K), .SHIFT(SHIFT), .RELU_EN(1), .DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(a_in_ready),
    .input_data(input_data), .output_valid(a_out_valid), .output_ready(output_ready),
    .output_data(a_out_data), .output_last(a_out_last), .sat_clear(sat_clear),
    .sat_count(a_sat)
  );

  vec3_requant #(.K(K), .SHIFT(SHIFT), .RELU_EN(0), .DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(b_in_ready),
    .input_data(input_data), .output_valid(b_out_valid), .output_ready(output_ready),
    .output_data(b_out_data), .output_last(b_out_last), .sat_clear(sat_clear),
    .sat_count(b_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   m_idx = 0;
  int   m_sat_a = 0;
  int   m_sat_b = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: floor division by 2**SHIFT, optional ReLU, clamp to 14-bit signed.
  function automatic void model(input logic [27:0] raw, input bit relu,
                                output int val, output bit sat);
    longint v, t, d;
    v = longint'($signed(raw));
    d = longint'(1) << SHIFT;
    t = v / d;
    if (v < 0 && (v % d) != 0) t = t - 1;
    if (relu && t < 0) t = 0;
    sat = 1'b0;
    if (t > 8191) begin
      t = 8191;
      sat = 1'b1;
    end else if (t < -8192) begin
      t = -8192;
      sat = 1'b1;
    end
    val = int'(t);
  endfunction

  function automatic logic [27:0] gen();
    int s;
    case ($urandom_range(0, 3))
      0: s = int'($urandom);
      1: s = int'($urandom_range(0, 2000000)) - 1000000;
      2: begin
        s = 1048576 + int'($urandom_range(0, 1024)) - 512;
        if ($urandom_range(0, 1) == 1) s = -s;
      end
      default: s = int'($urandom_range(0, 600)) - 300;
    endcase
    return 28'(s);
  endfunction

  // Output monitor: state after the last edge is checked at the falling edge.
  always begin
    @(negedge clk);
    if (!reset) begin
      check("a_out_valid", a_out_valid, q_a.size() != 0);
      check("b_out_valid", b_out_valid, q_b.size() != 0);
      check("a_in_ready", a_in_ready, q_a.size() < DEPTH);
      check("b_in_ready", b_in_ready, q_b.size() < DEPTH);
      if (a_out_valid && q_a.size() != 0) begin
        check("a_out_data", longint'($signed(a_out_data)), q_a[0].data);
        check("a_out_last", a_out_last, q_a[0].last);
        if (output_ready) void'(q_a.pop_front());
      end else if (!a_out_valid) begin
        check("a_idle_data", a_out_data, 0);
        check("a_idle_last", a_out_last, 0);
      end
      if (b_out_valid && q_b.size() != 0) begin
        check("b_out_data", longint'($signed(b_out_data)), q_b[0].data);
        check("b_out_last", b_out_last, q_b[0].last);
        if (output_ready) void'(q_b.pop_front());
      end else if (!b_out_valid) begin
        check("b_idle_data", b_out_data, 0);
        check("b_idle_last", b_out_last, 0);
      end
    end
  end

  // Input monitor: records each accepted element into the expected queues.
  always begin
    int  va, vb;
    bit  sa, sb, last;
    @(negedge clk);
    #1;
    if (reset) begin
      q_a.delete();
      q_b.delete();
      m_idx = 0;
      m_sat_a = 0;
      m_sat_b = 0;
    end else begin
      check("a_sat_count", a_sat, m_sat_a);
      check("b_sat_count", b_sat, m_sat_b);
      if (input_valid && a_in_ready) begin
        model(input_data, 1'b1, va, sa);
        model(input_data, 1'b0, vb, sb);
        last = (m_idx == K - 1);
        m_idx = last ? 0 : m_idx + 1;
        q_a.push_back('{data: va, last: last});
        q_b.push_back('{data: vb, last: last});
        if (sa && m_sat_a < 65535) m_sat_a++;
        if (sb && m_sat_b < 65535) m_sat_b++;
      end
      if (sat_clear) begin
        m_sat_a = 0;
        m_sat_b = 0;
      end
    end
  end

  task automatic send(input logic [27:0] d);
    bit acc;
    int n;
    input_valid = 1'b1;
    input_data  = d;
    n = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got not-accepted expected accepted");
    end
    input_valid = 1'b0;
    input_data  = 28'($urandom);
  endtask

  task automatic do_reset();
    input_valid = 1'b0;
    sat_clear   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_out_last", a_out_last, 0);
    check("rst_a_sat", a_sat, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_sat", b_sat, 0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    output_ready = 1'b1;
    input_valid  = 1'b0;
    sat_clear    = 1'b0;
    n = 0;
    while ((q_a.size() != 0 || a_out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_a_empty", q_a.size(), 0);
    check("drain_b_empty", q_b.size(), 0);
    check("drain_a_valid", a_out_valid, 0);
  endtask

  // {input, expected with ReLU, expected without ReLU}
  int dir_tab[14][3] = '{
    '{1280, 10, 10}, '{2097152, 8191, 8191}, '{-2097152, 0, -8192},
    '{-1280, 0, -10}, '{0, 0, 0}, '{127, 0, 0}, '{-1, 0, -1}, '{-129, 0, -2},
    '{1048448, 8191, 8191}, '{1048576, 8191, 8191}, '{-1048576, 0, -8192},
    '{-1048577, 0, -8192}, '{134217727, 8191, 8191}, '{-134217728, 0, -8192}
  };

  initial begin
    do_reset();
    output_ready = 1'b1;

    // Directed values: each is the head right after its accepting edge.
    for (int i = 0; i < 14; i++) begin
      send(28'(dir_tab[i][0]));
      check("dir_a_valid", a_out_valid, 1);
      check("dir_a_data", longint'($signed(a_out_data)), dir_tab[i][1]);
      check("dir_b_data", longint'($signed(b_out_data)), dir_tab[i][2]);
      if (i == 1) begin
        check("dir_a_sat_big", a_sat, 1);
        check("dir_b_sat_big", b_sat, 1);
      end
    end
    check("dir_a_sat_total", a_sat, 3);
    check("dir_b_sat_total", b_sat, 6);

    // Clear beats a simultaneous saturating push.
    sat_clear = 1'b1;
    send(28'(2097152));
    sat_clear = 1'b0;
    check("clr_a_sat", a_sat, 0);
    check("clr_b_sat", b_sat, 0);
    drain();

    // Back-pressure: fill, observe full, pop one, observe space.
    output_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(28'((i + 1) * 256));
    check("full_a_ready", a_in_ready, 0);
    check("full_b_ready", b_in_ready, 0);
    output_ready = 1'b1;
    @(posedge clk);
    #1;
    output_ready = 1'b0;
    check("pop1_a_ready", a_in_ready, 1);
    check("pop1_a_data", longint'($signed(a_out_data)), 4);
    drain();

    // Reset mid-vector restarts the element index.
    do_reset();
    output_ready = 1'b0;
    send(28'(1280));
    send(28'(2560));
    do_reset();
    output_ready = 1'b1;
    send(28'(384));
    check("rv_first_last", a_out_last, 0);
    send(28'(512));
    check("rv_second_last", a_out_last, 0);
    send(28'(640));
    check("rv_third_last", a_out_last, 1);
    check("rv_third_data", longint'($signed(a_out_data)), 5);
    drain();

    // Random traffic with occasional clears and one reset.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      input_valid  = ($urandom_range(0, 9) < 6);
      input_data   = gen();
      output_ready = ($urandom_range(0, 9) < 5);
      sat_clear    = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      #1;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
